// File: rtl/decoder_drive_seq.sv
// Channel scan sequencer driving the enable/select of a 2-to-4 decoder, with a
// one-cycle break-before-make gap between channels. SEQ_ONESHOT_EN: stop after one pass.
module decoder_drive_seq #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [3:0]         ch_mask,
  output logic [1:0]         sel,
  output logic               d_en,
  output logic               busy,
  output logic               wrap
);

`ifdef SEQ_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
`else
  localparam bit ONESHOT = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

  state_t             state_q, state_d;
  logic [1:0]         sel_q, sel_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               d_en_q, d_en_d;
  logic               busy_q, busy_d;
  logic               wrap_q, wrap_d;
  logic               gap_idle_q, gap_idle_d;

  logic [DWELL_W-1:0] dwell_eff;
  logic [1:0]         first_ch;
  logic [1:0]         next_ch;

  assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

  always_comb begin
    first_ch = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (ch_mask[i]) first_ch = 2'(i);
  end

  // First set bit strictly after sel_q, searching cyclically; falls back to sel_q itself.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    found   = 1'b0;
    next_ch = sel_q;
    idx     = sel_q;
    for (int k = 1; k <= 4; k++) begin
      idx = sel_q + 2'(k);
      if (!found && ch_mask[idx]) begin
        next_ch = idx;
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    wrap_d     = 1'b0;
    gap_idle_d = gap_idle_q;
    if (stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start && ch_mask != 4'd0) begin
          state_d = RUN;
          sel_d   = first_ch;
          cnt_d   = dwell_eff;
        end
        RUN: begin
          if (cnt_q > DWELL_W'(1)) begin
            cnt_d = cnt_q - DWELL_W'(1);
          end else begin
            // Mask is sampled once here; the GAP cycle just carries out the decision.
            state_d = GAP;
            if (ch_mask == 4'd0) begin
              gap_idle_d = 1'b1;
            end else begin
              sel_d      = next_ch;
              wrap_d     = (next_ch <= sel_q);
              gap_idle_d = ONESHOT && (next_ch <= sel_q);
            end
          end
        end
        GAP: begin
          if (gap_idle_q) begin
            state_d = IDLE;
          end else begin
            state_d = RUN;
            cnt_d   = dwell_eff;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    d_en_d = (state_d == RUN);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= 2'd0;
      cnt_q      <= '0;
      d_en_q     <= 1'b0;
      busy_q     <= 1'b0;
      wrap_q     <= 1'b0;
      gap_idle_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      d_en_q     <= d_en_d;
      busy_q     <= busy_d;
      wrap_q     <= wrap_d;
      gap_idle_q <= gap_idle_d;
    end
  end

  assign sel  = sel_q;
  assign d_en = d_en_q;
  assign busy = busy_q;
  assign wrap = wrap_q;

endmodule
